exp_sched: RTL

EXP_SCHED -- requirements
Module: exp_sched

---
 rtl/exp_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/exp_sched.sv
// -----------------------------------------------------------------------------
// exp_sched
// Lets NREQ requesters share one iterative exp (integer-log) datapath.
// Requests are granted round-robin in IDLE. The granted operands are latched
// and presented to the datapath. The result, or an error, is returned to the
// granted requester together with a one-cycle one-hot ack.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req[NREQ]            request levels, held with operands until acked
//   req_c/req_j          packed per-requester base / limit, slice i = [i*W +: W]
//   ack[NREQ]            one-cycle one-hot completion pulse
//   rsp_g, rsp_err       result and error flag, valid while ack != 0
//   busy                 high in every state except IDLE
//   exp_start            one-cycle start pulse to the datapath
//   exp_c, exp_j         latched operands, stable from LAUNCH through RESP
//   exp_clear            returns the datapath to its initial state
//   exp_done, exp_g      datapath completion level and result
// -----------------------------------------------------------------------------
module exp_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] req_c,
  input  logic [NREQ*W-1:0] req_j,
  output logic [NREQ-1:0] ack,
  output logic [W-1:0]    rsp_g,
  output logic            rsp_err,
  output logic            busy,
  output logic            exp_start,
  output logic [W-1:0]    exp_c,
  output logic [W-1:0]    exp_j,
  output logic            exp_clear,
  input  logic            exp_done,
  input  logic [W-1:0]    exp_g
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so the counter can never wrap inside a transaction.
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_q;
  logic [W-1:0]  c_q;
  logic [W-1:0]  j_q;
  logic [W-1:0]  g_q;
  logic          err_q;
  logic [CW-1:0] cnt;

  logic          pick_vld;
  logic [PW-1:0] pick;
  logic [W-1:0]  pick_c;
  logic [W-1:0]  pick_j;

  // Round-robin search: first set request bit starting at ptr, wrapping.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = PW'(idx);
      end
    end
    pick_c = req_c[int'(pick)*W +: W];
    pick_j = req_j[int'(pick)*W +: W];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of evaluation order.
  // NOTE: the holding registers are few, and all of them are reset. This makes
  // the datapath operands and the response outputs read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      ptr     <= '0;
      grant_q <= '0;
      c_q     <= '0;
      j_q     <= '0;
      g_q     <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_CLEAR: state <= S_IDLE;

        S_IDLE: begin
          if (pick_vld) begin
            grant_q <= pick;
            c_q     <= pick_c;
            j_q     <= pick_j;
            // A base below 2 has no meaningful log: answer at once with an
            // error and leave the datapath idle.
            if (pick_c < W'(2)) begin
              g_q   <= '0;
              err_q <= 1'b1;
              state <= S_RESP;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end

        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          // done is tested first, so it wins over a coincident timeout.
          if (exp_done) begin
            g_q   <= exp_g;
            err_q <= 1'b0;
            state <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            g_q   <= '1;
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RESP: begin
          ptr   <= (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
          state <= S_IDLE;
        end

        default: state <= S_CLEAR;
      endcase
    end
  end

  // Outputs decoded from registered state and holding registers only.
  assign ack       = (state == S_RESP) ? (NREQ'(1) << grant_q) : '0;
  assign rsp_g     = g_q;
  assign rsp_err   = err_q;
  assign busy      = (state != S_IDLE);
  assign exp_start = (state == S_LAUNCH);
  assign exp_clear = (state == S_CLEAR) || (state == S_RESP);
  assign exp_c     = c_q;
  assign exp_j     = j_q;

endmodule
